// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared op/state encodings and sizing for the iterative divider.
// Revision : 1.0
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration on {rem, quo}.
// Revision : 1.0
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_ge;

  // rem < dvsr always holds, so the shifted value and trial both fit WIDTH+1 bits
  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, i_dvsr};
  assign w_ge      = ~w_trial[WIDTH];

  assign o_rem = w_ge ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : iter_divider
// Purpose  : Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
//            Define DIV_EARLY_OUT_EN to skip iterations on special cases.
// Revision : 1.0
// ============================================================================
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int             c_cnt_w    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_dividend;
  logic             r_is_rem;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_div0;
  logic             r_ovf;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;

  div_op_e          w_op;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_fix_result;

  assign w_op     = div_op_e'(i_op);
  assign w_signed = (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_neg  = w_signed & i_dividend[WIDTH-1];
  assign w_b_neg  = w_signed & i_divisor[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (-i_dividend) : i_dividend;
  assign w_b_mag  = w_b_neg ? (-i_divisor) : i_divisor;
  assign w_div0   = (i_divisor == '0);
  assign w_ovf    = w_signed && (i_dividend == c_most_neg) && (i_divisor == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nxt),
    .o_quo  (w_quo_nxt)
  );

  assign w_quo_fix = r_q_neg ? (-r_quo) : r_quo;
  assign w_rem_fix = r_r_neg ? (-r_rem) : r_rem;

  // RISC-V special cases override whatever the iterations produced
  always_comb begin
    w_fix_result = r_is_rem ? w_rem_fix : w_quo_fix;
    if (r_div0) begin
      w_fix_result = r_is_rem ? r_dividend : '1;
    end else if (r_ovf) begin
      w_fix_result = r_is_rem ? '0 : r_dividend;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvsr     <= '0;
      r_dividend <= '0;
      r_is_rem   <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_result   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_cnt      <= c_cnt_w'(WIDTH - 1);
            r_rem      <= '0;
            r_quo      <= w_a_mag;
            r_dvsr     <= w_b_mag;
            r_dividend <= i_dividend;
            r_is_rem   <= i_op[1];
            r_q_neg    <= w_a_neg ^ w_b_neg;
            r_r_neg    <= w_a_neg;
            r_div0     <= w_div0;
            r_ovf      <= w_ovf;
            r_busy     <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            r_state    <= (w_div0 || w_ovf) ? ST_FIX : ST_DIV;
`else
            r_state    <= ST_DIV;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIX: begin
          r_result <= w_fix_result;
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_divider
// Purpose  : Self-checking bench for iter_divider against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_iter_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  iter_divider #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_op       (op),
    .i_dividend (a),
    .i_divisor  (b),
    .o_busy     (busy),
    .o_valid    (valid),
    .o_result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RISC-V semantics from plain arithmetic; 64-bit math sidesteps signed overflow
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    if (y == 0) return o[1] ? x : {W{1'b1}};
    if (!o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return o[1] ? W'(sx % sy) : W'(sx / sy);
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef DIV_EARLY_OUT_EN
    if (y == 0) return 2;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
`endif
    return W + 2;
  endfunction

  // Caller must be at posedge+1; poke>0 drives a stray start in that busy cycle
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int poke, input bit b2b);
    logic [W-1:0] e;
    int lat;
    int el;
    e  = model(o, x, y);
    el = exp_lat(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check("busy_issue", busy, 1);
    while (!valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == poke) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    check("latency", lat, el);
    check("result", result, e);
    check("busy_done", busy, 0);
    if (!b2b) begin
      @(posedge clk); #1;
      check("valid_pulse", valid, 0);
      check("hold", result, e);
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      3, 4:    return W'($urandom_range(300)) - 32'd150;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b01, 32'd100, 32'd7, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 0, 0);
    run_op(2'b00, -32'sd7, 32'd2, 0, 0);
    run_op(2'b10, -32'sd7, 32'd2, 0, 0);
    run_op(2'b00, 32'd7, -32'sd2, 0, 0);
    run_op(2'b10, 32'd7, -32'sd2, 0, 0);
    run_op(2'b01, 32'h1234, 32'd0, 0, 0);
    run_op(2'b10, 32'h1234, 32'd0, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    run_op(2'b01, 32'd1000, 32'd3, 5, 0);

    run_op(2'b00, 32'd50, -32'sd5, 0, 1);
    run_op(2'b11, 32'd77, 32'd10, 0, 0);

    op = 2'b01; a = 32'd999; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_result", result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    run_op(2'b01, 32'd999, 32'd4, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), rand_operand(), rand_operand(), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
